// File: rtl/zezima_pkg.sv
// Shared definitions for the move transmit path: sequencer state encodings,
// FIFO word layout and the trailer word builder.
package zezima_pkg;

    // Default width of one move word.
    localparam int MOVE_W_DEF = 16;

    // Width of one output FIFO word.
    localparam int FIFO_W = 32;

    // Upper half of the trailer word, marks it apart from move words.
    localparam logic [15:0] TRAILER_TAG = 16'hFFFF;

    // One-hot sequencer states.
    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_SPECIAL = 5'b00010,
        ST_ORDERED = 5'b00100,
        ST_TRAILER = 5'b01000,
        ST_DONE    = 5'b10000
    } tx_state_e;

    // Trailer word: tag, a zero byte, then the low byte of the move count.
    function automatic logic [FIFO_W-1:0] trailer_word(input logic [7:0] cnt8);
        trailer_word = {TRAILER_TAG, 8'h00, cnt8};
    endfunction

endpackage

// File: rtl/move_tx_sequencer_sat_counter.sv
// CNT_W-bit saturating up-counter with synchronous clear (clear wins over
// increment) and asynchronous active-low reset.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    // Count accepted moves, sticking at the all-ones value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= CNT_ZERO;
        end else if (i_clr) begin
            r_count <= CNT_ZERO;
        end else if (i_inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/move_tx_sequencer.sv
// move_tx_sequencer: per frame, drains the special-move source, then the
// ordered-move source, into the single CPU FIFO write port, optionally
// appends a move-count trailer word, then pulses frame_done.
// Optional feature macro: TX_TRAILER_EN (adds the TRAILER state and word).
// The write path and ready signals are combinational so a word moves in the
// same cycle as its handshake; state, busy, frame_done and the count are
// registered.
module move_tx_sequencer
    import zezima_pkg::*;
#(
    parameter int MOVE_W = MOVE_W_DEF,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sp_valid,
    input  logic [MOVE_W-1:0] sp_data,
    input  logic              sp_done,
    output logic              sp_ready,
    input  logic              mo_valid,
    input  logic [MOVE_W-1:0] mo_data,
    input  logic              mo_done,
    output logic              mo_ready,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [31:0]       fifo_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  move_count
);

    tx_state_e          r_state;
    logic               r_busy;
    logic               r_frame_done;

    logic               w_sp_ready;
    logic               w_mo_ready;
    logic               w_fifo_wr;
    logic [FIFO_W-1:0]  w_fifo_wdata;
    logic               w_move_xfer;
    logic               w_cnt_clr;
    logic [CNT_W-1:0]   w_count;

`ifdef TX_TRAILER_EN
    logic [7:0]         w_cnt8;

    // The trailer carries the count as exactly one byte.
    if (CNT_W >= 8) begin : g_cnt_trunc
        assign w_cnt8 = w_count[7:0];
    end else begin : g_cnt_ext
        assign w_cnt8 = {{(8-CNT_W){1'b0}}, w_count};
    end
`endif

    // Ready, write strobe and write data for the current state.
    always_comb begin
        w_sp_ready   = 1'b0;
        w_mo_ready   = 1'b0;
        w_fifo_wr    = 1'b0;
        w_fifo_wdata = {FIFO_W{1'b0}};
        w_move_xfer  = 1'b0;
        case (r_state)
            ST_SPECIAL: begin
                w_sp_ready = !fifo_full;
                if (sp_valid && !fifo_full) begin
                    w_fifo_wr    = 1'b1;
                    w_fifo_wdata = {{(FIFO_W-MOVE_W){1'b0}}, sp_data};
                    w_move_xfer  = 1'b1;
                end else begin
                    w_fifo_wr    = 1'b0;
                end
            end
            ST_ORDERED: begin
                w_mo_ready = !fifo_full;
                if (mo_valid && !fifo_full) begin
                    w_fifo_wr    = 1'b1;
                    w_fifo_wdata = {{(FIFO_W-MOVE_W){1'b0}}, mo_data};
                    w_move_xfer  = 1'b1;
                end else begin
                    w_fifo_wr    = 1'b0;
                end
            end
`ifdef TX_TRAILER_EN
            ST_TRAILER: begin
                if (!fifo_full) begin
                    w_fifo_wr    = 1'b1;
                    w_fifo_wdata = trailer_word(w_cnt8);
                end else begin
                    w_fifo_wr    = 1'b0;
                end
            end
`endif
            default: begin
                w_fifo_wr = 1'b0;
            end
        endcase
    end

    // Frame sequencing FSM with registered busy and frame_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_frame_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_SPECIAL;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_SPECIAL: begin
                    // A word still on offer is always taken before moving on.
                    if (sp_done && !sp_valid) begin
                        r_state <= ST_ORDERED;
                    end else begin
                        r_state <= ST_SPECIAL;
                    end
                end
                ST_ORDERED: begin
                    if (mo_done && !mo_valid) begin
`ifdef TX_TRAILER_EN
                        r_state      <= ST_TRAILER;
`else
                        r_state      <= ST_DONE;
                        r_frame_done <= 1'b1;
`endif
                    end else begin
                        r_state <= ST_ORDERED;
                    end
                end
`ifdef TX_TRAILER_EN
                ST_TRAILER: begin
                    if (!fifo_full) begin
                        r_state      <= ST_DONE;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_state <= ST_TRAILER;
                    end
                end
`endif
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                end
            endcase
        end
    end

    // The count restarts only on a start that actually opens a frame.
    assign w_cnt_clr = (r_state == ST_IDLE) && start;

    sat_counter #(
        .CNT_W   (CNT_W)
    ) u_move_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_move_xfer),
        .o_count (w_count)
    );

    assign sp_ready   = w_sp_ready;
    assign mo_ready   = w_mo_ready;
    assign fifo_wr    = w_fifo_wr;
    assign fifo_wdata = w_fifo_wdata;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign move_count = w_count;

endmodule
